decred_spi_host: RTL
====================

DECRED_SPI_HOST -- requirements
Module: decred_spi_host

Interface
REQ-001 Parameter SETUP_CYC, default 2: SPI_CLK cycles SCSN is low before the first SCLK low phase; legal range 1..15.
REQ-002 Parameter HALF_CYC, default 2: SPI_CLK cycles per SCLK half-period; legal range 1..15.
REQ-003 Parameter HOLD_CYC, default 2: SPI_CLK cycles of CS hold after the last bit, and of the CS-high gap before done; legal range 1..15.
REQ-004 SPI_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 SPI_CLK_RESET_N  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request a frame; sampled only when busy=0.
REQ-007 rw  in  1  1=write, 0=read; sampled with start.
REQ-008 addr  in  7  register address; sampled with start.
REQ-009 wdata  in  8  write data; sampled with start.
REQ-010 busy  out  1  frame in progress.
REQ-011 done  out  1  one-cycle pulse at frame completion.
REQ-012 rdata  out  8  data byte captured from MISO.
REQ-013 SCSN_toClient  out  1  chip select, active low.
REQ-014 SCLK_toClient  out  1  serial clock, CPOL=0.
REQ-015 MOSI_toClient  out  1  serial data to client, MSB first.
REQ-016 MISO_fromClient  in  1  serial data from client.
REQ-017 IRQ_OUT_fromClient  in  1  asynchronous active-high interrupt from client.
REQ-018 irq_level  out  1  synchronized IRQ level.
REQ-019 irq_pulse  out  1  one-cycle pulse on synchronized IRQ rising edge.

Function
REQ-020 The frame SHALL be 16 bits: bit15=rw, bits14:8=addr, bits7:0=wdata when rw=1, 8'h00 when rw=0.
REQ-021 The SPI mode SHALL be 0: MOSI changes on the SPI_CLK edge where SCLK falls; MISO is sampled on the edge where SCLK rises.
REQ-022 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, GAP, with no other reachable state.
REQ-023 In IDLE, start=1 at cycle 0 SHALL latch rw/addr/wdata and enter SETUP; from cycle 1, busy=1, SCSN=0, and MOSI=bit15.
REQ-024 SETUP SHALL last SETUP_CYC cycles with SCLK=0, then enter SHIFT.
REQ-025 SHIFT SHALL emit 16 bits, each bit being HALF_CYC cycles of SCLK=0 followed by HALF_CYC cycles of SCLK=1; the first SCLK rise SHALL occur at cycle 1+SETUP_CYC+HALF_CYC.
REQ-026 MISO SHALL be captured on the last 8 SCLK rises into an 8-bit shift register, MSB first; the first 8 rises SHALL be ignored.
REQ-027 After the 16th high phase, the FSM SHALL enter HOLD at cycle 1+SETUP_CYC+32*HALF_CYC with SCLK=0, MOSI=0, SCSN=0 for HOLD_CYC cycles.
REQ-028 GAP SHALL drive SCSN=1 for HOLD_CYC cycles; SCSN rises at cycle 1+SETUP_CYC+32*HALF_CYC+HOLD_CYC.
REQ-029 The cycle after GAP SHALL be IDLE with done=1 and busy=0, and rdata SHALL be updated from the shift register in that cycle, on read and write frames alike.
REQ-030 rdata SHALL hold its value until the next done.
REQ-031 start while busy=1 SHALL be ignored and not queued; start in the done cycle SHALL be accepted.
REQ-032 Bit and phase counters SHALL be sized from the parameters and SHALL NOT wrap within a frame.
REQ-033 IRQ_OUT_fromClient SHALL pass through a 2-flop synchronizer to irq_level; irq_pulse SHALL be 1 for exactly one cycle when irq_level transitions 0->1; a transition of the asynchronous input appears on irq_level 2 cycles later.

Reset
REQ-034 Assertion of SPI_CLK_RESET_N=0 SHALL immediately force: FSM=IDLE, SCSN=1, SCLK=0, MOSI=0, busy=0, done=0, rdata=8'h00, irq_level=0, irq_pulse=0, synchronizer flops=0.
REQ-035 Reset mid-frame SHALL abort the frame with no done pulse; after deassertion, the first start SHALL produce a complete, correct frame.

Verification
REQ-036 Defaults, write rw=1 addr=7'h12 wdata=8'hA5 -> MOSI bits 16'h92A5 on rises; SCSN low cycles 1..68; first rise at 5; done at 71.
REQ-037 Read rw=0 addr=7'h05, with the client model driving 8'h3C on data-byte falls -> MOSI=16'h0500; rdata=8'h3C at done.
REQ-038 start held high continuously for 3 frames -> exactly 3 frames; SCSN high for at least 2 cycles between frames; each done is followed by the next SCSN fall 1 cycle later.
REQ-039 Reset asserted at cycle 30 of a frame -> SCSN=1, SCLK=0 asynchronously; no done; the next frame is correct.
REQ-040 IRQ pulse 1->0 lasting 3 cycles -> irq_level high for 3 cycles, delayed by 2; exactly one irq_pulse.
REQ-041 Parameters SETUP_CYC=1, HALF_CYC=1, HOLD_CYC=1 -> first rise at cycle 3; done at cycle 36; the MOSI/MISO data checks of REQ-036 and REQ-037 pass.

Source files
------------

// File: rtl/decred_spi_host.sv
// SPI host for a Decred hashing client: one 16-bit mode-0 frame per request
// (rw, 7-bit address, data byte) with programmable setup/half-period/hold
// timing, plus a synchronizer and edge pulse for the client interrupt line.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | SCSN high, waiting for start; done pulses here after a frame
// ST_SETUP  | SCSN low, SCLK low, MOSI shows bit 15 for SETUP_CYC cycles
// ST_SHIFT  | 16 bits, each HALF_CYC low then HALF_CYC high; MISO on rises
// ST_HOLD   | SCSN still low, SCLK/MOSI low for HOLD_CYC cycles
// ST_GAP    | SCSN high for HOLD_CYC cycles before the frame is reported done
module decred_spi_host #(
   parameter int SETUP_CYC = 2,
   parameter int HALF_CYC  = 2,
   parameter int HOLD_CYC  = 2
) (
   input  logic       SPI_CLK,
   input  logic       SPI_CLK_RESET_N,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       SCSN_toClient,
   output logic       SCLK_toClient,
   output logic       MOSI_toClient,
   input  logic       MISO_fromClient,
   input  logic       IRQ_OUT_fromClient,
   output logic       irq_level,
   output logic       irq_pulse
);

   // Phase counter only ever holds (longest phase - 1), so it is sized to that.
   localparam int MAX_A = (SETUP_CYC > HALF_CYC) ? SETUP_CYC : HALF_CYC;
   localparam int MAX_C = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
   localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] HALF_LD  = CW'(HALF_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     bit_q, bit_d;
   logic [15:0]    tx_q, tx_d;
   logic [7:0]     rx_q, rx_d;
   logic [7:0]     rdata_q, rdata_d;
   logic           sclk_q, sclk_d;
   logic           mosi_q, mosi_d;
   logic           scsn_q, scsn_d;
   logic           done_q, done_d;
   logic           sync1_q, sync2_q, sync3_q;

   // Next-state and registered-output logic for the frame sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      scsn_d  = scsn_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
               bit_d   = 4'd15;
               tx_d    = {rw, addr, (rw ? wdata : 8'h00)};
               mosi_d  = rw;
               scsn_d  = 1'b0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_SHIFT;
               cnt_d   = HALF_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (!sclk_q) begin
               // Rising SCLK: the data byte occupies the last eight bits.
               sclk_d = 1'b1;
               cnt_d  = HALF_LD;
               if (bit_q < 4'd8) begin
                  rx_d = {rx_q[6:0], MISO_fromClient};
               end
            end else if (bit_q == 4'd0) begin
               state_d = ST_HOLD;
               sclk_d  = 1'b0;
               mosi_d  = 1'b0;
               cnt_d   = HOLD_LD;
            end else begin
               // Falling SCLK: present the next bit, MSB first.
               sclk_d = 1'b0;
               cnt_d  = HALF_LD;
               bit_d  = bit_q - 4'd1;
               mosi_d = tx_q[14];
               tx_d   = {tx_q[14:0], 1'b0};
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_GAP;
               scsn_d  = 1'b1;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               rdata_d = rx_q;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            scsn_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase
   end

   // Sequencer state and SPI pin registers.
   always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
      if (!SPI_CLK_RESET_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= 4'd0;
         tx_q    <= 16'h0000;
         rx_q    <= 8'h00;
         rdata_q <= 8'h00;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         scsn_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         scsn_q  <= scsn_d;
         done_q  <= done_d;
      end
   end

   // Two-flop interrupt synchronizer plus one delayed copy for edge detect.
   always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
      if (!SPI_CLK_RESET_N) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= IRQ_OUT_fromClient;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign rdata         = rdata_q;
   assign SCSN_toClient = scsn_q;
   assign SCLK_toClient = sclk_q;
   assign MOSI_toClient = mosi_q;
   assign irq_level     = sync2_q;
   assign irq_pulse     = sync2_q & ~sync3_q;

endmodule
